// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: the I-side request, the D-side request and the
// shared memory port. The arbiter takes the slave view; the environment
// (requesters plus memory) takes the master view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port to one-port memory arbiter: shares one memory port between the
// instruction-fetch side and the load/store side. One grant at a time; the
// granted address, write data and op are latched on the grant edge and held
// until mem_resp, which is routed combinationally to the granted side only.
// Optional feature: define MEM_ARB_RR_EN for round-robin between the two
// sides when both are pending; otherwise the D-side has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input logic           clk,
  input logic           rst_n,
  mem_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              op_write;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              i_pend;
  logic              d_pend;
  logic              grant_d;
  logic              grant_edge;

  assign i_pend     = bus.i_read;
  assign d_pend     = bus.d_read | bus.d_write;
  assign grant_edge = (state == IDLE) & (i_pend | d_pend);

`ifdef MEM_ARB_RR_EN
  // 0 = last grant went to I, 1 = last grant went to D
  logic last_grant;

  // On a tie, give the grant to the side that was not served last
  assign grant_d = d_pend & (~i_pend | ~last_grant);

  // Remember which side won each arbitration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_grant <= 1'b0;
    else if (grant_edge)
      last_grant <= grant_d;
  end
`else
  // D-side always wins a tie so loads/stores never stall behind fetch
  assign grant_d = d_pend;
`endif

  // Next-state: arbitrate in IDLE, hold the grant until memory completes
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_pend | d_pend)
          state_nxt = grant_d ? SERVE_D : SERVE_I;
      end
      SERVE_I, SERVE_D: begin
        if (bus.mem_resp)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset drops the strobes immediately since they decode state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Capture the winner's request on the grant edge; later input changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      op_write <= 1'b0;
    end else if (grant_edge) begin
      if (grant_d) begin
        addr_q   <= bus.d_addr;
        wdata_q  <= bus.d_wdata;
        // read+write together is illegal and resolves to a write
        op_write <= bus.d_write;
      end else begin
        addr_q   <= bus.i_addr;
        op_write <= 1'b0;
      end
    end
  end

  assign bus.mem_read  = (state != IDLE) & ~op_write;
  assign bus.mem_write = (state != IDLE) & op_write;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  // Completion is routed back in the same cycle to the granted side only
  assign bus.i_resp  = (state == SERVE_I) & bus.mem_resp;
  assign bus.d_resp  = (state == SERVE_D) & bus.mem_resp;
  assign bus.i_rdata = bus.mem_rdata;
  assign bus.d_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter. The driver issues requests and
// pushes the transactions it expects to see served, in the order the
// arbitration policy dictates; a monitor pops and compares on every resp.
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic rst_n;

  mem_arbiter_if #(.ADDR_W(16), .LINE_W(128)) bus ();

  mem_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           side_d;
    logic [15:0]  addr;
    bit           wr;
    logic [127:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   model_last_d = 1'b0;  // side served most recently (reference model)
  bit   hold = 1'b0;          // memory withholds responses
  bit   spur = 1'b0;          // memory emits a response with nothing in flight
  int   wcnt = 0;

  // Memory contents as a pure function of address
  function automatic logic [127:0] mem_fn(input logic [15:0] a);
    return {8{a ^ 16'hA5C3}};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Memory model: answers a strobed transaction after 0..3 extra cycles
  initial begin
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_resp = 1'b0;
      if (spur) begin
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = {4{$urandom}};
      end else if (!hold && (bus.mem_read || bus.mem_write)) begin
        if (wcnt == 0) begin
          bus.mem_resp  = 1'b1;
          bus.mem_rdata = mem_fn(bus.mem_addr);
          wcnt = $urandom_range(0, 3);
        end else begin
          wcnt--;
        end
      end
    end
  end

  // Monitor: every resp must match the next expected transaction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (bus.i_resp || bus.d_resp) begin
        chk("dual_resp", 128'(bus.i_resp & bus.d_resp), 128'(0));
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_resp: got i_resp=%0b d_resp=%0b want none", bus.i_resp, bus.d_resp);
        end else begin
          e = exp_q.pop_front();
          chk("resp_side", 128'(bus.d_resp), 128'(e.side_d));
          chk("mem_addr", 128'(bus.mem_addr), 128'(e.addr));
          chk("mem_write", 128'(bus.mem_write), 128'(e.wr));
          chk("mem_read", 128'(bus.mem_read), 128'(!e.wr));
          if (e.wr) chk("mem_wdata", bus.mem_wdata, e.wdata);
          chk("rdata", e.side_d ? bus.d_rdata : bus.i_rdata, mem_fn(e.addr));
        end
      end
    end
  end

  task automatic push_i(input logic [15:0] a);
    exp_t e;
    e.side_d = 1'b0; e.addr = a; e.wr = 1'b0; e.wdata = '0;
    exp_q.push_back(e);
    model_last_d = 1'b0;
  endtask

  task automatic push_d(input logic [15:0] a, input bit wr, input logic [127:0] wd);
    exp_t e;
    e.side_d = 1'b1; e.addr = a; e.wr = wr; e.wdata = wd;
    exp_q.push_back(e);
    model_last_d = 1'b1;
  endtask

  // Holds requests until each side sees its resp, then drops them
  task automatic wait_done(input bit ui, input bit ud, input bit mutate);
    bit i_done;
    bit d_done;
    bit first;
    int cyc;
    i_done = !ui; d_done = !ud; first = 1'b1; cyc = 0;
    while (!(i_done && d_done) && cyc < 100) begin
      @(posedge clk);
      #1;
      if (i_done) bus.i_read = 1'b0;
      if (d_done) begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
      if (mutate) begin
        bus.i_addr  = 16'($urandom);
        bus.d_addr  = 16'($urandom);
        bus.d_wdata = {4{$urandom}};
      end
      @(negedge clk);
      #3;
      if (first) chk("grant_latency", 128'(bus.mem_read | bus.mem_write), 128'(1));
      first = 1'b0;
      if (bus.i_resp) i_done = 1'b1;
      if (bus.d_resp) d_done = 1'b1;
      cyc++;
    end
    if (!(i_done && d_done)) begin
      n_checks++;
      $display("FAIL timeout: got no resp within %0d cycles want resp", cyc);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
  endtask

  // dkind: 0 read, 1 write, 2 read+write (served as a write)
  task automatic scenario(input bit ui, input bit ud, input int dkind,
                          input logic [15:0] ia, input logic [15:0] da,
                          input logic [127:0] wd, input bit mutate);
    bit wr;
    bit d_first;
    wr = (dkind != 0);
    if (ui && ud) begin
      d_first = RR ? !model_last_d : 1'b1;
      if (d_first) begin push_d(da, wr, wd); push_i(ia); end
      else begin push_i(ia); push_d(da, wr, wd); end
    end else if (ui) begin
      push_i(ia);
    end else begin
      push_d(da, wr, wd);
    end
    bus.i_addr  = ia;
    bus.d_addr  = da;
    bus.d_wdata = wd;
    bus.i_read  = ui;
    bus.d_read  = ud && (dkind != 1);
    bus.d_write = ud && (dkind != 0);
    wait_done(ui, ud, mutate);
  endtask

  initial begin
    bit ui;
    bit ud;
    bus.i_read = 1'b0; bus.i_addr = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #3;
    chk("rst_mem_read", 128'(bus.mem_read), 128'(0));
    chk("rst_mem_write", 128'(bus.mem_write), 128'(0));
    chk("rst_i_resp", 128'(bus.i_resp), 128'(0));
    chk("rst_d_resp", 128'(bus.d_resp), 128'(0));
    chk("rst_mem_addr", 128'(bus.mem_addr), 128'(0));
    chk("rst_mem_wdata", bus.mem_wdata, 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Lone I read, lone D write with inputs changing while served
    scenario(1'b1, 1'b0, 0, 16'h1234, 16'h0000, '0, 1'b0);
    scenario(1'b0, 1'b1, 1, 16'h0000, 16'h0040, {4{32'hDEADBEEF}}, 1'b1);
    scenario(1'b0, 1'b1, 0, 16'h0000, 16'h0040, '0, 1'b1);
    // Simultaneous requests
    repeat (4) scenario(1'b1, 1'b1, 0, 16'($urandom), 16'($urandom), {4{$urandom}}, 1'b0);
    // Illegal read+write resolves to a write
    scenario(1'b0, 1'b1, 2, 16'h0000, 16'h0BAD, {4{$urandom}}, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      ui = 1'($urandom_range(0, 1));
      ud = ui ? 1'($urandom_range(0, 1)) : 1'b1;
      scenario(ui, ud, $urandom_range(0, 2), 16'($urandom), 16'($urandom),
               {4{$urandom}}, (ui ^ ud) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    // Reset in the middle of an I transaction
    hold = 1'b1;
    bus.i_addr = 16'h2468;
    bus.i_read = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #3;
    chk("pre_rst_mem_read", 128'(bus.mem_read), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_read", 128'(bus.mem_read), 128'(0));
    chk("mid_rst_i_resp", 128'(bus.i_resp), 128'(0));
    chk("mid_rst_mem_addr", 128'(bus.mem_addr), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_last_d = 1'b0;
    hold = 1'b0;
    push_i(16'h2468);
    wait_done(1'b1, 1'b0, 1'b0);

    // Spurious mem_resp with nothing requested
    spur = 1'b1;
    @(negedge clk);
    #3;
    chk("spur_i_resp", 128'(bus.i_resp), 128'(0));
    chk("spur_d_resp", 128'(bus.d_resp), 128'(0));
    @(posedge clk);
    #1;
    spur = 1'b0;
    @(negedge clk);
    #3;
    chk("spur_idle_strobes", 128'(bus.mem_read | bus.mem_write), 128'(0));

    // Simultaneous requests again after the reset restored last_grant
    repeat (4) scenario(1'b1, 1'b1, $urandom_range(0, 2), 16'($urandom), 16'($urandom), {4{$urandom}}, 1'b0);

    repeat (3) @(posedge clk);
    chk("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
